// File: rtl/elastic_deserializer.sv
// Purpose : packs ratio_p narrow beats into one wide word; last_i flushes a partial word early.
// Latency : wide word is valid 1 cycle after its final beat is accepted.
// Backpressure: ready_o = ~valid_o | ready_i; a held word stalls all input beats.
// Optional build macro ELASTIC_DESERIALIZER_MSB_FIRST_EN: first beat lands in the MSBs instead of the LSBs.
module elastic_deserializer #(
    parameter  int width_p      = 8,
    parameter  int ratio_p      = 4,
    localparam int cnt_width_lp = $clog2(ratio_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [width_p-1:0]          data_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic                        ready_o,
    output logic                        valid_o,
    output logic [width_p*ratio_p-1:0]  data_o,
    output logic [cnt_width_lp-1:0]     count_o,
    input  logic                        ready_i
);

    localparam int                      idx_width_lp = $clog2(ratio_p);
    localparam logic [idx_width_lp-1:0] last_idx_lp  = idx_width_lp'(ratio_p - 1);

    logic [idx_width_lp-1:0]            r_idx;
    logic [ratio_p-1:0][width_p-1:0]    r_stage;
    logic [ratio_p-1:0][width_p-1:0]    r_data;
    logic [cnt_width_lp-1:0]            r_count;
    logic                               r_valid;

    logic [ratio_p-1:0][width_p-1:0]    w_merged;
    logic [idx_width_lp-1:0]            w_pos;
    logic                               w_ready;
    logic                               w_accept;
    logic                               w_final;
    logic                               w_drain;

    // Ready depends only on the held-word state and downstream ready, never on the input side.
    assign w_ready  = ~r_valid | ready_i;
    assign w_accept = valid_i & w_ready;
    assign w_final  = (r_idx == last_idx_lp) | last_i;
    assign w_drain  = r_valid & ready_i;

    assign ready_o  = w_ready;
    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign count_o  = r_count;

    // Map the logical beat index to its physical slot in the wide word.
    always_comb begin
`ifdef ELASTIC_DESERIALIZER_MSB_FIRST_EN
        w_pos = last_idx_lp - r_idx;
`else
        w_pos = r_idx;
`endif
    end

    // Staging buffer with the current beat dropped into its slot; unfilled slots stay zero.
    always_comb begin
        w_merged        = r_stage;
        w_merged[w_pos] = data_i;
    end

    // Beat collection, word hand-off and output-register drain.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idx   <= '0;
            r_stage <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_final) begin
                    // A final beat may load in the same edge the old word drains.
                    r_data  <= w_merged;
                    r_count <= cnt_width_lp'(r_idx) + cnt_width_lp'(1);
                    r_valid <= 1'b1;
                    r_stage <= '0;
                    r_idx   <= '0;
                end else begin
                    r_stage <= w_merged;
                    r_idx   <= r_idx + idx_width_lp'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_elastic_deserializer.sv
// Purpose : directed table-driven bench for elastic_deserializer (width 8, ratio 4).
// Latency : checks ready_o before each edge and the registered outputs 1 ns after it.
// Backpressure: exercises hold, same-edge drain/load, pulsed-ready streaming and reset mid-hold.
module tb_elastic_deserializer;

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  data_i  = '0;
    logic        valid_i = 1'b0;
    logic        last_i  = 1'b0;
    logic        ready_i = 1'b0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    elastic_deserializer #(.width_p(8), .ratio_p(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .count_o (count_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic        r;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_dat;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    // Expected words are written LSB-first; the MSB-first build mirrors slot order.
    function automatic logic [31:0] xp(input logic [31:0] w);
        logic [31:0] r;
`ifdef ELASTIC_DESERIALIZER_MSB_FIRST_EN
        for (int k = 0; k < 4; k++) r[(3-k)*8 +: 8] = w[k*8 +: 8];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic void add(input logic rst, input logic v, input logic l, input logic [7:0] d,
                                input logic r, input logic e_rdy, input logic e_vld,
                                input logic [31:0] e_dat, input logic [2:0] e_cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.d = d; t.r = r;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_dat = e_dat; t.e_cnt = e_cnt;
        tbl.push_back(t);
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, check ready_o before the edge and the registered outputs after it.
    task automatic step(input string name, input vec_t t);
        @(negedge clk_i);
        reset_i = t.rst; valid_i = t.v; last_i = t.l; data_i = t.d; ready_i = t.r;
        #1;
        check1({name, ".ready_o"}, ready_o, t.e_rdy);
        @(posedge clk_i);
        #1;
        check1({name, ".valid_o"}, valid_o, t.e_vld);
        check_w({name, ".data_o"}, data_o, xp(t.e_dat));
        if (t.e_vld) check_w({name, ".count_o"}, {29'd0, count_o}, {29'd0, t.e_cnt});
    endtask

    initial begin
        vec_t t;
        // rst v l d r | e_rdy e_vld e_dat e_cnt
        // Full word, back-to-back, ready_i high.
        add(0,1,0,8'h11,1, 1,0,32'h0,0);
        add(0,1,0,8'h22,1, 1,0,32'h0,0);
        add(0,1,0,8'h33,1, 1,0,32'h0,0);
        add(0,1,0,8'h44,1, 1,1,32'h44332211,4);
        add(0,0,0,8'h00,1, 1,0,32'h44332211,0);
        // Early flush, then last on a first beat with same-edge drain/load.
        add(0,1,0,8'hAA,1, 1,0,32'h44332211,0);
        add(0,1,1,8'hBB,1, 1,1,32'h0000BBAA,2);
        add(0,1,1,8'hCC,1, 1,1,32'h000000CC,1);
        // Hold: ready_o low, word stable, input beats refused.
        add(0,0,0,8'h00,0, 0,1,32'h000000CC,1);
        for (int i = 0; i < 5; i++) add(0,1,0,8'hDD,0, 0,1,32'h000000CC,1);
        add(0,1,0,8'hDD,1, 1,0,32'h000000CC,0);
        add(0,1,1,8'hEE,1, 1,1,32'h0000EEDD,2);
        add(0,0,0,8'h00,1, 1,0,32'h0000EEDD,0);
        // 16-beat stream, ready_i pulsed only while each word is shown.
        for (int w = 0; w < 4; w++) begin
            logic [31:0] prev, word;
            prev = (w == 0) ? 32'h0000EEDD : {8'(4*w), 8'(4*w-1), 8'(4*w-2), 8'(4*w-3)};
            word = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
            add(0,1,0,8'(4*w+1),(w != 0), 1,0,prev,0);
            add(0,1,0,8'(4*w+2),0, 1,0,prev,0);
            add(0,1,0,8'(4*w+3),0, 1,0,prev,0);
            add(0,1,0,8'(4*w+4),0, 1,1,word,4);
        end
        add(0,0,0,8'h00,1, 1,0,32'h100F0E0D,0);
        // Reset after a partial word; the next beat must land in slot 0.
        add(0,1,0,8'h55,1, 1,0,32'h100F0E0D,0);
        add(0,1,0,8'h66,1, 1,0,32'h100F0E0D,0);
        add(1,0,0,8'h00,1, 1,0,32'h0,0);
        add(0,1,0,8'h77,1, 1,0,32'h0,0);
        add(0,1,0,8'h88,1, 1,0,32'h0,0);
        add(0,1,0,8'h99,1, 1,0,32'h0,0);
        add(0,1,0,8'hAA,1, 1,1,32'hAA998877,4);
        add(0,0,0,8'h00,1, 1,0,32'hAA998877,0);
        // last_i without valid_i must not flush anything.
        add(0,0,1,8'h5A,1, 1,0,32'hAA998877,0);
        add(0,1,1,8'h12,1, 1,1,32'h00000012,1);
        add(0,0,0,8'h00,1, 1,0,32'h00000012,0);

        // Reset state.
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check1("reset.valid_o", valid_o, 1'b0);
        check_w("reset.data_o", data_o, 32'h0);
        check_w("reset.count_o", {29'd0, count_o}, 32'h0);
        check1("reset.ready_o", ready_o, 1'b1);

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Hand-written: full word held under backpressure, then reset discards it.
        t = '{rst:0, v:1, l:0, d:8'hF1, r:0, e_rdy:1, e_vld:0, e_dat:32'h00000012, e_cnt:0};
        step("hold.b0", t);
        t.d = 8'hF2; step("hold.b1", t);
        t.d = 8'hF3; step("hold.b2", t);
        t.d = 8'hF4; t.e_vld = 1; t.e_dat = 32'hF4F3F2F1; t.e_cnt = 4; step("hold.b3", t);
        t.d = 8'hF5; t.e_rdy = 0;
        for (int i = 0; i < 3; i++) step($sformatf("hold.stall%0d", i), t);
        t.rst = 1; t.v = 0; t.e_rdy = 0; t.e_vld = 0; t.e_dat = 32'h0; step("hold.reset", t);
        t.rst = 0; t.v = 1; t.l = 1; t.d = 8'h3C; t.r = 1; t.e_rdy = 1; t.e_vld = 1;
        t.e_dat = 32'h0000003C; t.e_cnt = 1; step("hold.after_reset", t);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
